// File: rtl/kan_axis_pkg.sv
// Shared AXI-Stream scheduling types and the round-robin pick helper.
// The helper rotates the request vector by the pointer, priority-encodes it, then rotates the result back.
package kan_axis_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } sched_state_t;

  localparam int RR_MAX = 32;
  localparam int RR_IW  = 5;

  // First set bit of valid[0..n-1] at or after ptr, wrapping at n; returns ptr when none set.
  function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
    logic [RR_MAX-1:0] rot;
    int idx;
    int pos;
    rot = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n) rot[i] = valid[idx[RR_IW-1:0]];
    end
    pos = 0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    idx = ptr + pos;
    if (idx >= n) idx = idx - n;
    return idx;
  endfunction

endpackage

// File: rtl/axis_register.sv
// Valid/ready register slice. REG_TYPE=2: two-entry skid (full throughput, registered ready);
// REG_TYPE=1: single register with combinational ready pass-through.
module axis_register #(
  parameter int REG_TYPE = 2,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] r_m_data;
  logic             r_m_valid;

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;

  generate
    if (REG_TYPE == 2) begin : g_skid
      logic [WIDTH-1:0] r_sk_data;
      logic             r_sk_valid;

      assign s_ready = !r_sk_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_m_valid  <= 1'b0;
          r_sk_valid <= 1'b0;
        end else if (!r_m_valid || m_ready) begin
          // Output slot frees up: the skid entry (older) always goes first.
          if (r_sk_valid) begin
            r_m_data   <= r_sk_data;
            r_m_valid  <= 1'b1;
            r_sk_valid <= 1'b0;
          end else begin
            r_m_valid <= s_valid;
            if (s_valid) r_m_data <= s_data;
          end
        end else if (s_valid && !r_sk_valid) begin
          r_sk_data  <= s_data;
          r_sk_valid <= 1'b1;
        end
      end
    end else begin : g_reg
      assign s_ready = !r_m_valid || m_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_m_valid <= 1'b0;
        end else if (s_ready) begin
          r_m_valid <= s_valid;
          if (s_valid) r_m_data <= s_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axis_rr_scheduler.sv
// Round-robin scheduler sharing one AXI-Stream sink among CHANNELS requesters, per beat or per packet.
// The granted index travels with each beat through the output skid stage and appears on m_axis_tid.
module axis_rr_scheduler
  import kan_axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (KEEP_ENABLE != 0) ? ((DATA_WIDTH + 7) / 8) : 1,
  parameter int CHANNELS    = 4,
  parameter int PACKET_MODE = 1,
  parameter int USER_ENABLE = 0,
  parameter int USER_WIDTH  = (USER_ENABLE != 0) ? 8 : 1,
  parameter int SEL_WIDTH   = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [SEL_WIDTH-1:0]           m_axis_tid,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  input  logic                           cfg_enable,
  output logic                           stat_busy,
  output logic [SEL_WIDTH-1:0]           stat_grant
);

  localparam int KEEP_LSB = DATA_WIDTH;
  localparam int LAST_BIT = KEEP_LSB + KEEP_WIDTH;
  localparam int USER_LSB = LAST_BIT + 1;
  localparam int TID_LSB  = USER_LSB + USER_WIDTH;
  localparam int PAY_W    = TID_LSB + SEL_WIDTH;
  localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(CHANNELS - 1);

  sched_state_t          r_state, w_state_nxt;
  logic [SEL_WIDTH-1:0]  r_ptr, r_grant;
  logic [SEL_WIDTH-1:0]  w_sel, w_cur, w_ptr_inc;
  logic                  w_grant_vld, w_acc, w_last, w_skid_rdy;
  logic [PAY_W-1:0]      w_pay, w_m_pay;

  assign w_sel     = SEL_WIDTH'(rr_pick(RR_MAX'(s_axis_tvalid), int'(r_ptr), CHANNELS));
  assign w_ptr_inc = (w_cur == LAST_CH) ? '0 : w_cur + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_grant <= w_cur;
        if (w_state_nxt == ST_IDLE) r_ptr <= w_ptr_inc;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cur         = r_grant;
    w_grant_vld   = 1'b0;
    s_axis_tready = '0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_enable && (|s_axis_tvalid)) begin
          w_cur       = w_sel;
          w_grant_vld = 1'b1;
        end
      end
      ST_LOCKED: w_grant_vld = 1'b1;
      default:   w_grant_vld = 1'b0;
    endcase
    // No handshakes while reset is held, so nothing leaks past a mid-packet reset.
    if (rst) w_grant_vld = 1'b0;
    s_axis_tready[w_cur] = w_grant_vld && w_skid_rdy;
    w_last = s_axis_tlast[w_cur];
    w_acc  = w_grant_vld && w_skid_rdy && s_axis_tvalid[w_cur];
    if (w_acc) begin
      if ((PACKET_MODE != 0) && !w_last) w_state_nxt = ST_LOCKED;
      else                               w_state_nxt = ST_IDLE;
    end
  end

  assign w_pay = {w_cur,
                  s_axis_tuser[w_cur*USER_WIDTH +: USER_WIDTH],
                  w_last,
                  s_axis_tkeep[w_cur*KEEP_WIDTH +: KEEP_WIDTH],
                  s_axis_tdata[w_cur*DATA_WIDTH +: DATA_WIDTH]};

  axis_register #(
    .REG_TYPE (2),
    .WIDTH    (PAY_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .s_data  (w_pay),
    .s_valid (w_acc),
    .s_ready (w_skid_rdy),
    .m_data  (w_m_pay),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign m_axis_tdata = w_m_pay[DATA_WIDTH-1:0];
  assign m_axis_tlast = w_m_pay[LAST_BIT];
  assign m_axis_tid   = w_m_pay[TID_LSB +: SEL_WIDTH];
  assign m_axis_tkeep = (KEEP_ENABLE != 0) ? w_m_pay[KEEP_LSB +: KEEP_WIDTH] : '1;
  assign m_axis_tuser = (USER_ENABLE != 0) ? w_m_pay[USER_LSB +: USER_WIDTH] : '0;

  assign stat_busy  = (r_state == ST_LOCKED);
  assign stat_grant = r_grant;

endmodule

// File: tb/tb_axis_rr_scheduler.sv
// Randomised and directed checks of axis_rr_scheduler against a queue-based scheduling model.
module tb_axis_rr_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Packet-mode instance (4 channels, tkeep and tuser enabled)
  logic        rst = 1'b1, cfg_en = 1'b1;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic [3:0]  s_tvalid = '0, s_tready, s_tlast = '0;
  logic [31:0] s_tuser = '0;
  logic [15:0] m_tdata;
  logic [1:0]  m_tkeep, m_tid, grant;
  logic        m_tvalid, m_tready = 1'b1, m_tlast, busy;
  logic [7:0]  m_tuser;

  axis_rr_scheduler #(.DATA_WIDTH(16), .CHANNELS(4), .PACKET_MODE(1), .USER_ENABLE(1)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tuser(m_tuser), .cfg_enable(cfg_en), .stat_busy(busy), .stat_grant(grant));

  // Beat-mode instance
  logic        b_rst = 1'b1, b_on = 1'b0;
  logic [63:0] b_tdata = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
  logic [7:0]  b_tkeep = 8'hFF;
  logic [3:0]  b_tvalid = '0, b_tready, b_tlast = '0, b_tuser = '0;
  logic [15:0] b_mdata;
  logic [1:0]  b_mkeep, b_mtid, b_grant;
  logic        b_mvalid, b_mlast, b_busy;
  logic [0:0]  b_muser;

  axis_rr_scheduler #(.DATA_WIDTH(16), .CHANNELS(4), .PACKET_MODE(0), .USER_ENABLE(0)) dut_b (
    .clk(clk), .rst(b_rst), .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
    .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .s_axis_tuser(b_tuser), .m_axis_tdata(b_mdata),
    .m_axis_tkeep(b_mkeep), .m_axis_tvalid(b_mvalid), .m_axis_tready(1'b1), .m_axis_tlast(b_mlast),
    .m_axis_tid(b_mtid), .m_axis_tuser(b_muser), .cfg_enable(1'b1), .stat_busy(b_busy), .stat_grant(b_grant));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- source / sink driver ----------------
  int          seq[4], pos[4], plen[4];
  logic [15:0] dbase[4];
  bit          en[4];
  int          prob = 100, fixed_len = 0, mr_mode = 0;
  bit          src_clr = 1'b0;
  logic [3:0]  hs = '0;

  function automatic int new_len();
    return (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
  endfunction

  task automatic set_fields(input int c);
    s_tdata[c*16 +: 16] = dbase[c] + 16'(seq[c]);
    s_tkeep[c*2 +: 2]   = 2'($urandom_range(0, 3));
    s_tuser[c*8 +: 8]   = 8'($urandom_range(0, 255));
    s_tlast[c]          = (pos[c] == plen[c] - 1);
  endtask

  task automatic drive_step();
    for (int c = 0; c < 4; c++) begin
      if (src_clr) begin
        seq[c] = 0; pos[c] = 0; plen[c] = new_len(); s_tvalid[c] = 1'b0;
      end else if (hs[c]) begin
        seq[c]++;
        if (pos[c] == plen[c] - 1) begin pos[c] = 0; plen[c] = new_len(); end
        else pos[c]++;
      end
      if (src_clr || hs[c]) set_fields(c);
      // A presented beat is held until accepted; otherwise valid is re-drawn.
      if (!(s_tvalid[c] && !hs[c])) s_tvalid[c] = en[c] && ($urandom_range(0, 99) < prob);
    end
    src_clr = 1'b0;
    case (mr_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 99) < 65);
    endcase
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      dbase[c] = 16'(c << 12); en[c] = 1'b0; seq[c] = 0; pos[c] = 0; plen[c] = 1;
    end
    forever begin
      @(posedge clk); #1;
      drive_step();
    end
  end

  // ---------------- behavioural model + compare ----------------
  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
    logic [7:0]  u;
    int          id;
  } beat_t;

  beat_t       mq[$];
  int          own = -1, rr = 0, gnt = 0;
  bit          chk_on = 1'b0;
  int          out_tids[$];
  logic [15:0] out_data[$];

  always @(negedge clk) begin
    logic [3:0] er;
    int         pick;
    beat_t      b;
    hs = s_tvalid & s_tready;
    if (chk_on) begin
      if (m_tvalid && m_tready) begin
        out_tids.push_back(int'(m_tid));
        if (m_tid == 2'd1) out_data.push_back(m_tdata);
      end
      // Owner keeps the grant; otherwise first valid channel from the rr pointer, if enabled.
      er = '0;
      pick = -1;
      if (!rst) begin
        if (own >= 0) pick = own;
        else if (cfg_en)
          for (int k = 0; k < 4; k++)
            if (pick < 0 && s_tvalid[2'((rr + k) % 4)]) pick = (rr + k) % 4;
        if (pick >= 0 && mq.size() < 2) er[2'(pick)] = 1'b1;
      end
      chk("tready", 64'(s_tready), 64'(er));
      chk("m_tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        b = mq[0];
        chk("m_tdata", 64'(m_tdata), 64'(b.d));
        chk("m_tkeep", 64'(m_tkeep), 64'(b.k));
        chk("m_tlast", 64'(m_tlast), 64'(b.l));
        chk("m_tuser", 64'(m_tuser), 64'(b.u));
        chk("m_tid", 64'(m_tid), 64'(b.id));
      end
      chk("stat_busy", 64'(busy), 64'(own >= 0));
      chk("stat_grant", 64'(grant), 64'(gnt));
      if (rst) begin
        mq.delete(); own = -1; rr = 0; gnt = 0;
      end else begin
        if (mq.size() != 0 && m_tready) void'(mq.pop_front());
        for (int c = 0; c < 4; c++) begin
          if (er[c] && s_tvalid[c]) begin
            b.d = s_tdata[c*16 +: 16]; b.k = s_tkeep[c*2 +: 2]; b.l = s_tlast[c];
            b.u = s_tuser[c*8 +: 8];   b.id = c;
            mq.push_back(b);
            gnt = c;
            if (!s_tlast[c]) own = c;
            else begin own = -1; rr = (c + 1) % 4; end
          end
        end
      end
    end
  end

  int b_tids[$];
  always @(negedge clk) begin
    if (b_on && !b_rst) begin
      chk("b_busy", 64'(b_busy), 64'(0));
      if (b_mvalid) begin
        b_tids.push_back(int'(b_mtid));
        chk("b_data", 64'(b_mdata), 64'(16'(int'(b_mtid) * 16'h1111)));
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic restart();
    rst = 1'b1; src_clr = 1'b1;
    step(2);
    rst = 1'b0;
    out_tids.delete(); out_data.delete();
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return busy;
      1:       return m_tvalid;
      default: return s_tready[0];
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic want, input int lim, input string nm);
    int i = 0;
    while (get_sig(sel) !== want && i < lim) begin step(1); i++; end
    chk(nm, 64'(get_sig(sel)), 64'(want));
  endtask

  task automatic set_en(input logic [3:0] m);
    for (int c = 0; c < 4; c++) en[c] = m[c];
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    step(3);
    chk_on = 1'b1;

    // Reset asserted during traffic
    rst = 1'b0; set_en(4'hF); prob = 70; fixed_len = 0; mr_mode = 2;
    step(30);
    rst = 1'b1;
    step(1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tready", 64'(s_tready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));

    // Whole-packet round robin, 3-beat packets, sink always ready
    prob = 100; fixed_len = 3; mr_mode = 0;
    restart();
    step(20);
    chk("p2_count", 64'(out_tids.size() >= 12), 64'(1));
    for (int i = 0; i < 12 && i < out_tids.size(); i++) chk("p2_tid", 64'(out_tids[i]), 64'(i / 3));

    // Granted ch2 idles mid-packet while ch0 waits
    set_en(4'b0100); fixed_len = 6;
    restart();
    wait_sig(0, 1'b1, 20, "p4_locked");
    en[2] = 1'b0; en[0] = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("p4_ch0_blocked", 64'(s_tready[0]), 64'(0));
      chk("p4_grant_held", 64'(grant), 64'(2));
      step(1);
    end
    en[2] = 1'b1;
    wait_sig(0, 1'b0, 30, "p4_unlock");
    wait_sig(2, 1'b1, 10, "p4_ch0_served");

    // cfg_enable dropped mid-packet
    set_en(4'hF); fixed_len = 5;
    restart();
    wait_sig(0, 1'b1, 20, "p6_locked");
    cfg_en = 1'b0;
    wait_sig(0, 1'b0, 20, "p6_pkt_done");
    for (int i = 0; i < 4; i++) begin
      chk("p6_tready", 64'(s_tready), 64'(0));
      step(1);
    end
    wait_sig(1, 1'b0, 10, "p6_drained");
    cfg_en = 1'b1;

    // Toggling sink ready, single source with incrementing data
    set_en(4'b0010); dbase[1] = 16'hA001; fixed_len = 0; mr_mode = 1;
    restart();
    step(40);
    set_en(4'b0000); mr_mode = 0;
    step(8);
    chk("p5_count", 64'(out_data.size() >= 10), 64'(1));
    for (int i = 0; i < out_data.size(); i++) chk("p5_data", 64'(out_data[i]), 64'(16'hA001 + 16'(i)));

    // Long randomised run
    dbase[1] = 16'h1000; set_en(4'hF); mr_mode = 2; fixed_len = 0;
    restart();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) prob = int'($urandom_range(20, 100));
      if ($urandom_range(0, 99) < 2) cfg_en = ~cfg_en;
      if ($urandom_range(0, 999) < 3) begin
        rst = 1'b1; step(2); rst = 1'b0;
      end else step(1);
    end
    cfg_en = 1'b1;

    // Per-beat instance: channels 1 and 3, then all four
    b_on = 1'b1; b_tvalid = 4'b1010;
    step(1);
    b_rst = 1'b0;
    step(14);
    chk("p3_count", 64'(b_tids.size() >= 6), 64'(1));
    for (int i = 0; i < 6 && i < b_tids.size(); i++) chk("p3_tid", 64'(b_tids[i]), 64'((i % 2 == 0) ? 1 : 3));
    b_rst = 1'b1;
    step(2);
    b_tids.delete(); b_tvalid = 4'hF; b_rst = 1'b0;
    step(10);
    chk("p3b_count", 64'(b_tids.size() >= 6), 64'(1));
    for (int i = 0; i < 6 && i < b_tids.size(); i++) chk("p3b_tid", 64'(b_tids[i]), 64'(i % 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
